// File: rtl/data_mem.sv
// data_mem: simple dual-port synchronous data memory (frame-buffer storage).
// One write port and one registered read port with independent addresses on
// a shared clock. Both enables are active-low. Reset asynchronously clears
// every stored word and the read register.

module data_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage array: cleared on reset, written when wr_en is low.
    // NOTE: the contents must read back as zero right after reset, so the
    // array is built from resettable flops rather than a RAM macro; a RAM
    // cannot be cleared asynchronously in one step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!wr_en) begin
            // NOTE: non-blocking update is what makes a same-address read in
            // this cycle see the old word (read-before-write).
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port: loads on rd_en low, otherwise holds its value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (!rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed scoreboard bench for data_mem. Stimulus pushes the
// expected read-port value into a queue when it asks for a check; a monitor
// on the falling edge pops and compares whenever a check is due.

module tb_data_mem;

    localparam int DW = 16;
    localparam int AW = 3;

    typedef struct {
        logic [DW-1:0] exp;
        string         name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b1;
    logic          rd_en = 1'b1;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic chk_req = 1'b0;
    logic chk_due = 1'b0;

    data_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wr_addr(wr_addr),
        .rd_addr(rd_addr),
        .wr_data(wr_data),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // A check requested in a cycle becomes due after that cycle's rising edge.
    always @(posedge clk) chk_due <= chk_req;

    // Monitor: compare rd_data against the head of the scoreboard.
    always @(negedge clk) begin
        if (chk_due) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.name, rd_data, e.exp);
            end
        end
    end

    // One clock cycle of stimulus, driven on the falling edge.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra,
                       input logic do_chk, input logic [DW-1:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        chk_req = do_chk;
        if (do_chk) begin
            e.exp  = exp;
            e.name = name;
            sb_q.push_back(e);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(1'b0, a, d, 1'b1, '0, 1'b0, '0, "");
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        cyc(1'b1, '0, '0, 1'b0, a, 1'b1, exp, name);
    endtask

    task automatic idle();
        cyc(1'b1, '0, '0, 1'b1, '0, 1'b0, '0, "");
    endtask

    initial begin
        // Reset held across an edge with a write and read requested.
        #1 reset = 1'b0;
        #1 check("reset_rd_data", rd_data, 16'h0000);
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0001;
        rd_en = 1'b0; rd_addr = 3'd0;
        @(posedge clk); #1;
        check("reset_hold_rd_data", rd_data, 16'h0000);
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1;
        reset = 1'b1;
        rd(3'd0, 16'h0000, "reset_no_write_addr0");

        // Write/read back.
        wr(3'd1, 16'h0002);
        wr(3'd3, 16'h0004);
        rd(3'd1, 16'h0002, "rd_addr1");
        rd(3'd3, 16'h0004, "rd_addr3");
        rd(3'd2, 16'h0000, "rd_addr2_unwritten");

        // Idle enables.
        cyc(1'b1, 3'd1, 16'h5555, 1'b1, 3'd0, 1'b0, '0, "");
        rd(3'd1, 16'h0002, "wr_en_high_no_write");
        cyc(1'b1, '0, '0, 1'b1, 3'd6, 1'b1, 16'h0002, "rd_en_high_hold");
        cyc(1'b1, '0, '0, 1'b1, 3'd3, 1'b1, 16'h0002, "rd_en_high_hold2");

        // Same-address collision: read-before-write.
        wr(3'd5, 16'h00AA);
        cyc(1'b0, 3'd5, 16'h00BB, 1'b0, 3'd5, 1'b1, 16'h00AA, "collision_old_data");
        rd(3'd5, 16'h00BB, "collision_new_data");

        // Simultaneous write and read at different addresses.
        cyc(1'b0, 3'd6, 16'h0066, 1'b0, 3'd3, 1'b1, 16'h0004, "rw_diff_addr_read");
        rd(3'd6, 16'h0066, "rw_diff_addr_written");

        // Asynchronous reset mid-run.
        for (int i = 0; i < 8; i++) wr(i[AW-1:0], 16'hFFFF);
        rd(3'd4, 16'hFFFF, "fill_rd_addr4");
        idle();
        @(posedge clk); #2;
        reset = 1'b0;
        #1 check("async_reset_immediate", rd_data, 16'h0000);
        wr_en = 1'b0; wr_addr = 3'd2; wr_data = 16'h1234;
        rd_en = 1'b0; rd_addr = 3'd4;
        @(posedge clk); #1;
        check("async_reset_hold", rd_data, 16'h0000);
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) rd(i[AW-1:0], 16'h0000, $sformatf("cleared_addr%0d", i));

        // Full sweep, read back in reverse.
        for (int i = 0; i < 8; i++) wr(i[AW-1:0], 16'(i + 16'h0010));
        for (int i = 7; i >= 0; i--) rd(i[AW-1:0], 16'(i + 16'h0010), $sformatf("sweep_addr%0d", i));

        idle();
        idle();
        idle();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
